mem_port_arbiter: RTL

- Sequences and shares one single-port memory between the instruction-fetch port (I) and the load/store port (D) of the multicycle core.
- Sits between the control unit/datapath and the unified memory.
- Grants one transaction at a time with round-robin fairness, latches the address and write data, waits for the memory handshake and returns read data with a valid pulse.
- Aborts with an error if the memory stalls beyond a bound.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (I) and
// load/store (D) ports; one transaction at a time, with an optional stall timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t             state;
  logic               last_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic               pick_i;
  logic               pick_d;
  logic               timeout_hit;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick_i      = i_req && (!d_req || last_d);
    pick_d      = d_req && !pick_i;
    timeout_hit = (MAX_WAIT != 0) && (wait_cnt == CNT_W'(MAX_WAIT - 1)) && !mem_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      wait_cnt  <= '0;
      i_gnt     <= 1'b0;
      i_valid   <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_i) begin
            state     <= BUSY_I;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            i_gnt     <= 1'b1;
            last_d    <= 1'b0;
            wait_cnt  <= '0;
          end else if (pick_d) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            d_gnt     <= 1'b1;
            last_d    <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Completion takes priority over a timeout expiring in the same cycle.
          if (mem_ready || timeout_hit) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == BUSY_I) begin
              i_valid <= 1'b1;
              i_err   <= !mem_ready;
              i_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_valid <= 1'b1;
              d_err   <= !mem_ready;
              if (!mem_ready)
                d_rdata <= '0;
              else if (!mem_we)
                d_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
